id_control_stage: RTL and testbench

Parametrised ID-stage control unit for the five-stage MIPS pipeline. It decodes the 6-bit opcode of the instruction in IF/ID into the main control vector and registers that vector, together with the register specifiers, into the ID/EX control register. It detects load-use hazards and inserts bubbles, honours branch flushes and downstream holds, and keeps a saturating count of inserted bubbles. It sits between the IF/ID register and the EX stage, and it drives PC and IF/ID write enables.

---
 rtl/mips_ctrl_pkg.sv | 38 +++
 rtl/main_decoder.sv | 52 +++++
 rtl/id_control_stage.sv | 117 +++++++++++
 tb/tb_id_control_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS ID-stage control logic.
//   - opcode constants for the supported instruction subset
//   - ALUOp encodings
//   - ctrl_t: packed main-control vector produced by the decoder
//   - uses_rt(): whether an opcode reads rt as a source operand
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) ||
           (opcode == OP_BEQ)   || (opcode == OP_BNE);
  endfunction

endpackage

// File: rtl/main_decoder.sv
// Main control decoder: combinational opcode -> control vector.
//   opcode_i : instr[31:26]
//   ctrl_o   : decoded control vector; unknown opcodes decode to a NOP (all zeros)
module main_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = ALUOP_SUB;
      end
      OP_BNE: begin
        ctrl_o.branch_ne = 1'b1;
        ctrl_o.alu_op    = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      OP_J: begin
        ctrl_o.jump   = 1'b1;
        ctrl_o.alu_op = ALUOP_ADD;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/id_control_stage.sv
// ID-stage control unit: decodes the IF/ID opcode, registers control and register
// specifiers into ID/EX, detects load-use hazards (inserting one bubble each), honours
// flush/hold, and counts inserted bubbles with saturation.
//   clk, reset_n           : clock, synchronous active-low reset
//   id_opcode/rs/rt/rd     : instruction fields from IF/ID
//   flush, hold            : squash ID instruction / freeze ID/EX, PC and IF/ID
//   pc_write, ifid_write   : combinational fetch-side load enables
//   ex_*                   : registered ID/EX control bits and specifiers
//   bubble_count           : saturating count of hazard bubbles
module id_control_stage
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W   = 2,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned CNT_W     = 16,
  parameter bit          HAZARD_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         id_opcode,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               flush,
  input  logic               hold,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic               ex_mem_to_reg,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_branch,
  output logic               ex_branch_ne,
  output logic               ex_jump,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [CNT_W-1:0]   bubble_count
);

  ctrl_t             dec_ctrl;
  ctrl_t             ctrl_d, ctrl_q;
  logic [REG_AW-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              hazard;
  logic              bubble;

  main_decoder u_main_decoder (
    .opcode_i (id_opcode),
    .ctrl_o   (dec_ctrl)
  );

  // Load in EX whose destination is read by the instruction in ID; $0 never conflicts.
  always_comb begin
    hazard = HAZARD_EN && ctrl_q.mem_read && (rt_q != '0) &&
             ((rt_q == id_rs) || (uses_rt(id_opcode) && (rt_q == id_rt)));
  end

  assign bubble     = hazard && !flush && !hold;
  assign pc_write   = !(hold || (hazard && !flush));
  assign ifid_write = pc_write;

  always_comb begin
    ctrl_d = ctrl_q;
    rs_d   = rs_q;
    rt_d   = rt_q;
    rd_d   = rd_q;
    if (flush || !hold) begin
      ctrl_d = (flush || hazard) ? '0 : dec_ctrl;
      rs_d   = id_rs;
      rt_d   = id_rt;
      rd_d   = id_rd;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bubble && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ex_reg_dst    = ctrl_q.reg_dst;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_branch     = ctrl_q.branch;
  assign ex_branch_ne  = ctrl_q.branch_ne;
  assign ex_jump       = ctrl_q.jump;
  assign ex_alu_op     = {{(ALUOP_W-2){1'b0}}, ctrl_q.alu_op};
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_rd         = rd_q;
  assign bubble_count  = cnt_q;

endmodule

// File: tb/tb_id_control_stage.sv
// Directed bench for id_control_stage. Two instances share stimulus: a default one and one
// with a 2-bit counter and 3-bit ALUOp to exercise saturation and ALUOp zero-extension.
module tb_id_control_stage;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       flush, hold;

  logic        pc_write, ifid_write;
  logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
  logic        branch, branch_ne, jump;
  logic [1:0]  alu_op;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [15:0] bcnt;

  logic        pc_write2, ifid_write2;
  logic        reg_dst2, alu_src2, mem_to_reg2, reg_write2, mem_read2, mem_write2;
  logic        branch2, branch_ne2, jump2;
  logic [2:0]  alu_op2;
  logic [4:0]  ex_rs2, ex_rt2, ex_rd2;
  logic [1:0]  bcnt2;

  int checks   = 0;
  int failures = 0;

  localparam logic [10:0] V_R    = 11'b1_0_0_1_0_0_0_0_0_10;
  localparam logic [10:0] V_LW   = 11'b0_1_1_1_1_0_0_0_0_00;
  localparam logic [10:0] V_SW   = 11'b0_1_0_0_0_1_0_0_0_00;
  localparam logic [10:0] V_BEQ  = 11'b0_0_0_0_0_0_1_0_0_01;
  localparam logic [10:0] V_BNE  = 11'b0_0_0_0_0_0_0_1_0_01;
  localparam logic [10:0] V_ADDI = 11'b0_1_0_1_0_0_0_0_0_00;
  localparam logic [10:0] V_J    = 11'b0_0_0_0_0_0_0_0_1_00;

  logic [5:0]  sweep_op  [8];
  logic [10:0] sweep_exp [8];

  always #5 clk = ~clk;

  id_control_stage u_dut (
    .clk(clk), .reset_n(reset_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .flush(flush), .hold(hold), .pc_write(pc_write), .ifid_write(ifid_write),
    .ex_reg_dst(reg_dst), .ex_alu_src(alu_src), .ex_mem_to_reg(mem_to_reg),
    .ex_reg_write(reg_write), .ex_mem_read(mem_read), .ex_mem_write(mem_write),
    .ex_branch(branch), .ex_branch_ne(branch_ne), .ex_jump(jump), .ex_alu_op(alu_op),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .bubble_count(bcnt)
  );

  id_control_stage #(.ALUOP_W(3), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .flush(flush), .hold(hold), .pc_write(pc_write2),
    .ifid_write(ifid_write2), .ex_reg_dst(reg_dst2), .ex_alu_src(alu_src2),
    .ex_mem_to_reg(mem_to_reg2), .ex_reg_write(reg_write2), .ex_mem_read(mem_read2),
    .ex_mem_write(mem_write2), .ex_branch(branch2), .ex_branch_ne(branch_ne2),
    .ex_jump(jump2), .ex_alu_op(alu_op2), .ex_rs(ex_rs2), .ex_rt(ex_rt2), .ex_rd(ex_rd2),
    .bubble_count(bcnt2)
  );

  function automatic logic [10:0] vec1();
    return {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
            branch, branch_ne, jump, alu_op};
  endfunction

  function automatic logic [11:0] vec2();
    return {reg_dst2, alu_src2, mem_to_reg2, reg_write2, mem_read2, mem_write2,
            branch2, branch_ne2, jump2, alu_op2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Both instances must agree on control; the 3-bit ALUOp has a zero top bit.
  task automatic chk_ctrl(input string tag, input logic [10:0] exp);
    chk(tag, {21'd0, vec1()}, {21'd0, exp});
    chk({tag, "_w3"}, {20'd0, vec2()}, {20'd0, exp[10:2], 1'b0, exp[1:0]});
  endtask

  task automatic chk_en(input string tag, input logic exp);
    chk(tag, {30'd0, pc_write, ifid_write}, {30'd0, exp, exp});
    chk({tag, "_2"}, {30'd0, pc_write2, ifid_write2}, {30'd0, exp, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
  endtask

  task automatic load_use(input string tag);
    set_id(6'b100011, 5'd1, 5'd8, 5'd0);
    step();
    set_id(6'b000000, 5'd8, 5'd2, 5'd4);
    #1;
    chk_en({tag, "_stall"}, 1'b0);
    step();
    chk_ctrl({tag, "_bubble"}, 11'd0);
    chk_en({tag, "_release"}, 1'b1);
    step();
    chk_ctrl({tag, "_issue"}, V_R);
  endtask

  initial begin
    sweep_op[0] = 6'b000000; sweep_exp[0] = V_R;
    sweep_op[1] = 6'b100011; sweep_exp[1] = V_LW;
    sweep_op[2] = 6'b101011; sweep_exp[2] = V_SW;
    sweep_op[3] = 6'b000100; sweep_exp[3] = V_BEQ;
    sweep_op[4] = 6'b000101; sweep_exp[4] = V_BNE;
    sweep_op[5] = 6'b001000; sweep_exp[5] = V_ADDI;
    sweep_op[6] = 6'b000010; sweep_exp[6] = V_J;
    sweep_op[7] = 6'b111111; sweep_exp[7] = 11'd0;

    // Reset while an R-type sits in ID
    reset_n = 1'b0;
    flush   = 1'b0;
    hold    = 1'b0;
    set_id(6'b000000, 5'd1, 5'd2, 5'd3);
    step();
    step();
    chk_ctrl("reset_ctrl", 11'd0);
    chk("reset_spec", {17'd0, ex_rs, ex_rt, ex_rd}, 32'd0);
    chk_en("reset_en", 1'b1);
    chk("reset_cnt", {16'd0, bcnt}, 32'd0);
    chk("reset_cnt2", {30'd0, bcnt2}, 32'd0);

    // Decode sweep; rt = 0 keeps the lw from creating a hazard
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_id(sweep_op[i], 5'd1, 5'd0, 5'd3);
      step();
      chk_ctrl($sformatf("sweep_%0d", i), sweep_exp[i]);
    end
    chk("sweep_spec", {17'd0, ex_rs, ex_rt, ex_rd}, {17'd0, 5'd1, 5'd0, 5'd3});

    // Load-use: lw rt=8 then R-type rs=8
    load_use("lu1");
    chk("lu1_rd", {27'd0, ex_rd}, 32'd4);
    chk("lu1_cnt", {16'd0, bcnt}, 32'd1);
    chk("lu1_cnt2", {30'd0, bcnt2}, 32'd1);

    // lw to $0 followed by a use of $0: no stall
    set_id(6'b100011, 5'd1, 5'd0, 5'd0);
    step();
    set_id(6'b000000, 5'd0, 5'd0, 5'd5);
    #1;
    chk_en("zero_nostall", 1'b1);
    step();
    chk_ctrl("zero_issue", V_R);

    // lw rt=9 followed by addi with rt=9 (rt is a destination): no stall
    set_id(6'b100011, 5'd1, 5'd9, 5'd0);
    step();
    set_id(6'b001000, 5'd1, 5'd9, 5'd0);
    #1;
    chk_en("addi_nostall", 1'b1);
    step();
    chk_ctrl("addi_issue", V_ADDI);
    chk("addi_cnt", {16'd0, bcnt}, 32'd1);

    // Flush overrides a pending hazard
    set_id(6'b100011, 5'd1, 5'd8, 5'd0);
    step();
    set_id(6'b000000, 5'd8, 5'd2, 5'd7);
    flush = 1'b1;
    #1;
    chk_en("flush_en", 1'b1);
    step();
    flush = 1'b0;
    chk_ctrl("flush_ctrl", 11'd0);
    chk("flush_rd", {27'd0, ex_rd}, 32'd7);
    chk("flush_cnt", {16'd0, bcnt}, 32'd1);

    // Hold for 3 cycles freezes ID/EX
    set_id(6'b001000, 5'd1, 5'd5, 5'd0);
    step();
    set_id(6'b101011, 5'd2, 5'd6, 5'd0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_en($sformatf("hold_en_%0d", i), 1'b0);
      step();
      chk_ctrl($sformatf("hold_ctrl_%0d", i), V_ADDI);
      chk($sformatf("hold_rt_%0d", i), {27'd0, ex_rt}, 32'd5);
    end
    hold = 1'b0;

    // Hold during a pending hazard: no bubble until hold drops
    set_id(6'b100011, 5'd1, 5'd8, 5'd0);
    step();
    set_id(6'b000000, 5'd8, 5'd2, 5'd4);
    hold = 1'b1;
    step();
    chk_ctrl("hhaz_frozen", V_LW);
    chk("hhaz_cnt", {16'd0, bcnt}, 32'd1);
    hold = 1'b0;
    #1;
    chk_en("hhaz_stall", 1'b0);
    step();
    chk_ctrl("hhaz_bubble", 11'd0);
    chk("hhaz_cnt2", {16'd0, bcnt}, 32'd2);
    step();
    chk_ctrl("hhaz_issue", V_R);

    // Four more load-use pairs: 6 bubbles total, 2-bit counter saturates at 3
    for (int i = 0; i < 4; i++) load_use($sformatf("sat%0d", i));
    chk("sat_cnt", {16'd0, bcnt}, 32'd6);
    chk("sat_cnt2", {30'd0, bcnt2}, 32'd3);

    // Reset mid-stall
    set_id(6'b100011, 5'd1, 5'd8, 5'd0);
    step();
    set_id(6'b000000, 5'd8, 5'd2, 5'd4);
    #1;
    chk_en("rst_stall", 1'b0);
    reset_n = 1'b0;
    step();
    chk_ctrl("rst_ctrl", 11'd0);
    chk_en("rst_release", 1'b1);
    chk("rst_cnt", {16'd0, bcnt}, 32'd0);
    chk("rst_cnt2", {30'd0, bcnt2}, 32'd0);
    reset_n = 1'b1;
    step();
    chk_ctrl("post_rst", V_R);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
